// File: rtl/priority_request_server.sv
// Sticky request collector with a valid/ready grant server.
// The highest pending index is offered first, and a bit clears once its grant is accepted.
module priority_request_server #(
    parameter int unsigned N    = 4,
    parameter int unsigned IDXW = 2,
    parameter int unsigned CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_in,
    input  logic            grant_ready,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic [N-1:0]    pending,
    output logic            z,
    output logic [CNTW-1:0] grant_count
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

    logic [0:0]      state;
    logic [0:0]      state_next;
    logic            valid_next;
    logic [IDXW-1:0] idx_next;
    logic [N-1:0]    pending_next;
    logic [CNTW-1:0] count_next;

    logic            accept;
    logic [N-1:0]    clr;
    logic [N-1:0]    cand;

    // Highest set index wins; a later loop iteration overrides an earlier one.
    function automatic logic [IDXW-1:0] hi_index(input logic [N-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v[i]) begin
                r = IDXW'(i);
            end
        end
        return r;
    endfunction

    // Clear the served bit. Requests arriving this cycle are not candidates yet.
    always_comb begin
        accept = grant_valid & grant_ready;
        clr    = '0;
        if (accept) begin
            clr[grant_idx] = 1'b1;
        end
        cand         = pending & ~clr;
        pending_next = cand | req_in;
    end

    always_comb begin
        state_next = state;
        valid_next = grant_valid;
        idx_next   = grant_idx;
        count_next = grant_count;
        case (state)
            IDLE: begin
                if (cand != '0) begin
                    idx_next   = hi_index(cand);
                    valid_next = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                // An open offer is never preempted; it moves only on accept.
                if (accept) begin
                    count_next = grant_count + CNTW'(1);
                    if (cand != '0) begin
                        idx_next = hi_index(cand);
                    end else begin
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            pending     <= '0;
            grant_count <= '0;
        end else begin
            state       <= state_next;
            grant_valid <= valid_next;
            grant_idx   <= idx_next;
            pending     <= pending_next;
            grant_count <= count_next;
        end
    end

    assign z = |pending;

endmodule

// File: tb/tb_priority_request_server.sv
// Bench for priority_request_server: table-driven vectors checked through a scoreboard queue,
// followed by a long back-to-back run that covers counter wrap.
module tb_priority_request_server;

    logic       clk;
    logic       reset;
    logic [3:0] req_in;
    logic       grant_ready;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] pending;
    logic       z;
    logic [7:0] grant_count;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic       v;
        logic [1:0] idx;
        logic [3:0] p;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks;
    int   n_fail;

    priority_request_server #(.N(4), .IDXW(2), .CNTW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .grant_ready (grant_ready),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .pending     (pending),
        .z           (z),
        .grant_count (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, and compare after the edge.
    task automatic apply(input vec_t v, input string nm);
        vec_t e;
        @(negedge clk);
        reset       = v.rst;
        req_in      = v.req;
        grant_ready = v.rdy;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({nm, " sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({nm, " valid"},   32'(grant_valid), 32'(e.v));
            check({nm, " idx"},     32'(grant_idx),   32'(e.idx));
            check({nm, " pending"}, 32'(pending),     32'(e.p));
            check({nm, " count"},   32'(grant_count), 32'(e.cnt));
            check({nm, " z"},       32'(z),           32'(e.p != 4'h0));
        end
    endtask

    initial begin
        vec_t v;
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        req_in      = 4'hF;
        grant_ready = 1'b0;

        // {rst, req, rdy, exp_valid, exp_idx, exp_pending, exp_count}
        // T1 reset held with all requests high
        vecs.push_back('{1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 8'd0});
        vecs.push_back('{1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 8'd0});
        vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 8'd0});
        // T2 drain 0101 with ready held high
        vecs.push_back('{1'b0, 4'h5, 1'b1, 1'b0, 2'd0, 4'h5, 8'd0});
        vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 4'h5, 8'd0});
        vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 8'd1});
        vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 8'd2});
        vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 8'd2});
        // T3 hold: higher request during an open offer does not preempt
        vecs.push_back('{1'b0, 4'h2, 1'b0, 1'b0, 2'd0, 4'h2, 8'd2});
        vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 4'h2, 8'd2});
        vecs.push_back('{1'b0, 4'h8, 1'b0, 1'b1, 2'd1, 4'hA, 8'd2});
        vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 4'hA, 8'd2});
        vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 4'h8, 8'd3});
        // T4 collision: served and re-requested bit stays pending, then is re-offered
        vecs.push_back('{1'b0, 4'h8, 1'b1, 1'b0, 2'd3, 4'h8, 8'd4});
        vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 2'd3, 4'h8, 8'd4});
        vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 2'd3, 4'h0, 8'd5});
        // T5 reset during an offer with pending 0110
        vecs.push_back('{1'b0, 4'h6, 1'b0, 1'b0, 2'd3, 4'h6, 8'd5});
        vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 2'd2, 4'h6, 8'd5});
        vecs.push_back('{1'b1, 4'h1, 1'b1, 1'b0, 2'd0, 4'h0, 8'd0});
        vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 8'd0});

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // T6 wrap: all requests every cycle yield one accept per cycle after the first offer
        for (int k = 1; k <= 260; k++) begin
            v.rst = 1'b0;
            v.req = 4'hF;
            v.rdy = 1'b1;
            v.p   = 4'hF;
            if (k == 1) begin
                v.v   = 1'b0;
                v.idx = 2'd0;
                v.cnt = 8'd0;
            end else begin
                v.v   = 1'b1;
                v.idx = (k % 2 == 0) ? 2'd3 : 2'd2;
                v.cnt = 8'(k - 2);
            end
            apply(v, $sformatf("wrap%0d", k));
        end

        // Drain from pending=F, count 2, offering idx 3; then ready while idle must not count
        apply('{1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 4'h7, 8'd3}, "drain0");
        apply('{1'b0, 4'h0, 1'b1, 1'b1, 2'd1, 4'h3, 8'd4}, "drain1");
        apply('{1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 8'd5}, "drain2");
        apply('{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 8'd6}, "drain3");
        for (int k = 0; k < 3; k++) begin
            apply('{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 8'd6}, $sformatf("idle_rdy%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
